// File: rtl/vga_pmod_receiver.sv
// vga_pmod_receiver: samples the VGA PMOD bus, verifies 640x480@60 timing,
// reconstructs pixel coordinates/colour and counts lit pixels per frame.
module vga_pmod_receiver #(
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned H_OFFSET  = 143,
  parameter int unsigned V_OFFSET  = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pmod_in,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  rgb,
  output logic        frame_start,
  output logic        timing_error,
  output logic [18:0] lit_count
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned LIT_W = 19;
  localparam int unsigned RGB_W = 6;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LINES = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_OFFSET);
  localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_OFFSET + H_DISPLAY);
  localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_OFFSET);
  localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_OFFSET + V_DISPLAY);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t             state;
  logic               hs_prev;
  logic               vs_prev;
  logic               armed;
  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   k_cnt;
  logic [CNT_W-1:0]   line_total;
  logic [LIT_W-1:0]   lit_acc;

  logic               hsync;
  logic               vsync;
  logic [RGB_W-1:0]   rgb_in;
  logic               h_rise;
  logic               v_rise;
  logic               arm_now;
  logic [CNT_W-1:0]   h_now;
  logic [CNT_W-1:0]   k_now;
  logic               line_err;
  logic               frame_err;
  logic               any_err;
  logic               active;
  logic               stay_locked;

  // Decode the bus, detect sync edges and derive this sample's position and checks
  always_comb begin
    hsync   = pmod_in[7];
    vsync   = pmod_in[3];
    rgb_in  = {pmod_in[0], pmod_in[4], pmod_in[1], pmod_in[5], pmod_in[2], pmod_in[6]};
    h_rise  = hsync & ~hs_prev;
    v_rise  = vsync & ~vs_prev;
    arm_now = armed | v_rise;

    h_now = h_cnt;
    if (h_rise) begin
      h_now = '0;
    end else if (h_cnt != CNT_MAX) begin
      h_now = CNT_W'(h_cnt + 1'b1);
    end

    k_now = k_cnt;
    if (h_rise) begin
      if (arm_now) begin
        k_now = '0;
      end else if (k_cnt != CNT_MAX) begin
        k_now = CNT_W'(k_cnt + 1'b1);
      end
    end

    // The first line after a vsync rise is exempt: its start is not yet framed
    line_err  = h_rise & ~arm_now & (h_cnt != H_LAST);
    frame_err = v_rise & (line_total != V_LINES);
    any_err   = line_err | frame_err;

    active = (h_now >= H_LO) && (h_now < H_HI) && (k_now >= V_LO) && (k_now < V_HI);

    // True when the state after this sample is LOCKED
    stay_locked = ~any_err & ((state == LOCKED) | ((state == MEASURE) & v_rise));
  end

  // Sync history, horizontal/line counters and the per-frame hsync tally
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev    <= 1'b1;
      vs_prev    <= 1'b1;
      armed      <= 1'b0;
      h_cnt      <= '0;
      k_cnt      <= '0;
      line_total <= '0;
    end else begin
      hs_prev <= hsync;
      vs_prev <= vsync;
      armed   <= h_rise ? 1'b0 : arm_now;
      h_cnt   <= h_now;
      k_cnt   <= k_now;
      if (v_rise) begin
        line_total <= CNT_W'(h_rise);
      end else if (h_rise && line_total != CNT_MAX) begin
        line_total <= CNT_W'(line_total + 1'b1);
      end
    end
  end

  // Lock FSM with registered status, pixel and lit-count outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SEARCH;
      locked       <= 1'b0;
      frame_start  <= 1'b0;
      timing_error <= 1'b0;
      lit_acc      <= '0;
      lit_count    <= '0;
      pix_valid    <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      rgb          <= '0;
    end else begin
      frame_start  <= 1'b0;
      timing_error <= any_err & (state != SEARCH);
      locked       <= stay_locked;

      case (state)
        SEARCH:  if (v_rise) state <= MEASURE;
        MEASURE: begin
          if (any_err)     state <= SEARCH;
          else if (v_rise) state <= LOCKED;
        end
        LOCKED:  if (any_err) state <= SEARCH;
        default: state <= SEARCH;
      endcase

      // The accumulator is only meaningful while locked; entry publishes the empty count
      if (!stay_locked) begin
        lit_acc <= '0;
      end else if (v_rise) begin
        lit_count   <= lit_acc;
        lit_acc     <= '0;
        frame_start <= 1'b1;
      end else if ((state == LOCKED) && active && (rgb_in != '0)) begin
        lit_acc <= LIT_W'(lit_acc + 1'b1);
      end

      pix_valid <= stay_locked & active;
      if (stay_locked && active) begin
        pix_x <= CNT_W'(h_now - H_LO);
        pix_y <= CNT_W'(k_now - V_LO);
        rgb   <= rgb_in;
      end
    end
  end

endmodule

// File: tb/tb_vga_pmod_receiver.sv
// Scoreboard bench for vga_pmod_receiver using a reduced frame geometry.
module tb_vga_pmod_receiver;

  localparam int unsigned HT = 20;
  localparam int unsigned VT = 12;
  localparam int unsigned HD = 8;
  localparam int unsigned VD = 4;
  localparam int unsigned HO = 5;
  localparam int unsigned VO = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pmod_in;
  logic        locked;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [5:0]  rgb;
  logic        frame_start;
  logic        timing_error;
  logic [18:0] lit_count;

  always #5 clk = ~clk;

  vga_pmod_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_DISPLAY(HD),
    .V_DISPLAY(VD), .H_OFFSET(HO), .V_OFFSET(VO)
  ) dut (
    .clk(clk), .reset(reset), .pmod_in(pmod_in), .locked(locked),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .rgb(rgb),
    .frame_start(frame_start), .timing_error(timing_error), .lit_count(lit_count)
  );

  typedef struct {time t; logic [9:0] x; logic [9:0] y; logic [5:0] c;} px_t;
  typedef struct {time t; logic [18:0] lit;} fs_t;
  typedef struct {time t; logic v;} lk_t;

  px_t px_q[$];
  fs_t fs_q[$];
  time err_q[$];
  lk_t lk_q[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic prev_locked = 1'b0;
  bit cur_locked = 1'b0;
  logic [18:0] held_lit = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=asserted required=no pending expectation at %0t", name, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin : monitor
    px_t p;
    fs_t f;
    lk_t k;
    time e;
    if (mon_en) begin
      if (pix_valid === 1'b1) begin
        if (px_q.size() == 0) unexpected("pix_extra");
        else begin
          p = px_q.pop_front();
          check("pix_time", 64'($time), 64'(p.t));
          check("pix_xyrgb", 64'({pix_x, pix_y, rgb}), 64'({p.x, p.y, p.c}));
        end
      end
      if (frame_start === 1'b1) begin
        if (fs_q.size() == 0) unexpected("frame_start_extra");
        else begin
          f = fs_q.pop_front();
          check("fs_time", 64'($time), 64'(f.t));
          check("lit_count", 64'(lit_count), 64'(f.lit));
        end
      end
      if (timing_error === 1'b1) begin
        if (err_q.size() == 0) unexpected("timing_error_extra");
        else begin
          e = err_q.pop_front();
          check("err_time", 64'($time), 64'(e));
        end
      end
      if (locked !== prev_locked) begin
        if (lk_q.size() == 0) unexpected("locked_change_extra");
        else begin
          k = lk_q.pop_front();
          check("lock_time", 64'($time), 64'(k.t));
          check("lock_val", 64'(locked), 64'(k.v));
        end
        prev_locked = locked;
      end
    end
  end

  function automatic logic [7:0] enc(input bit hs, input bit vs, input logic [5:0] c);
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  function automatic logic [5:0] pat_rgb(input int pat, input int x, input int y);
    logic [2:0] xb;
    logic [1:0] yb;
    xb = 3'(x);
    yb = 2'(y);
    case (pat)
      1:       return 6'h3F;
      2:       return ((x == 0 && y == 0) || (x == int'(HD) - 1 && y == int'(VD) - 1)) ? 6'h3F : 6'h00;
      3:       return (x == 3 && y == 2) ? 6'h30 : 6'h00;
      4:       return {yb, xb, xb[0] ^ yb[0]};
      default: return 6'h00;
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset   = 1'b0;
      pmod_in = 8'h00;
    end
  endtask

  // vs_ev at the frame's vsync rise: 0 none, 1 lock + frame_start, 2 frame_start, 3 frame error
  task automatic frame(input int nlines, input int long_line, input int pat, input int vs_ev,
                       input logic [18:0] exp_lit, input int rst_line);
    bit rst_chk = 1'b0;
    bit lit_chk = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < ((l == long_line) ? int'(HT) + 1 : int'(HT)); c++) begin
        bit r;
        bit in_area;
        logic [5:0] col;
        time t;
        @(negedge clk);
        t = $time;
        r = 1'b0;
        if (rst_chk) begin
          check("rst_outputs", 64'({locked, pix_valid, pix_x, pix_y, rgb, frame_start, timing_error, lit_count}), 64'(0));
          rst_chk = 1'b0;
        end
        if (lit_chk) begin
          check("lit_hold", 64'(lit_count), 64'(held_lit));
          lit_chk = 1'b0;
        end
        if (l == 0 && c == 0) begin
          case (vs_ev)
            1: begin
              lk_q.push_back('{t + 10, 1'b1});
              fs_q.push_back('{t + 10, exp_lit});
              cur_locked = 1'b1;
              held_lit = exp_lit;
            end
            2: begin
              fs_q.push_back('{t + 10, exp_lit});
              held_lit = exp_lit;
            end
            3: begin
              err_q.push_back(t + 10);
              lk_q.push_back('{t + 10, 1'b0});
              cur_locked = 1'b0;
              lit_chk = 1'b1;
            end
            default: ;
          endcase
        end
        if (long_line >= 0 && l == long_line + 1 && c == 0) begin
          err_q.push_back(t + 10);
          lk_q.push_back('{t + 10, 1'b0});
          cur_locked = 1'b0;
          lit_chk = 1'b1;
        end
        if (l == rst_line && c == 0) begin
          r = 1'b1;
          if (cur_locked) lk_q.push_back('{t + 10, 1'b0});
          cur_locked = 1'b0;
          rst_chk = 1'b1;
        end
        in_area = (c >= int'(HO)) && (c < int'(HO + HD)) && (l >= int'(VO)) && (l < int'(VO + VD));
        col = in_area ? pat_rgb(pat, c - int'(HO), l - int'(VO)) : 6'h3F;
        if (in_area && cur_locked)
          px_q.push_back('{t + 10, 10'(c - int'(HO)), 10'(l - int'(VO)), col});
        reset   = r;
        pmod_in = enc(c < 2, l < 2, col);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    pmod_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({locked, pix_valid, pix_x, pix_y, rgb, frame_start, timing_error, lit_count}), 64'(0));
    mon_en = 1'b1;
    idle(5);
    frame(VT, -1, 4, 0, 19'd0,  -1);  // enter MEASURE
    frame(VT, -1, 4, 1, 19'd0,  -1);  // lock, partial count 0
    frame(VT, -1, 1, 2, 19'd31, -1);
    frame(VT, -1, 0, 2, 19'd32, -1);
    frame(VT, -1, 3, 2, 19'd0,  -1);
    frame(VT, -1, 2, 2, 19'd1,  -1);
    frame(VT,  4, 1, 2, 19'd2,  -1);  // stretched line -> unlock
    frame(VT, -1, 1, 0, 19'd0,  -1);
    frame(VT, -1, 2, 1, 19'd0,  -1);  // relock
    frame(VT - 1, -1, 1, 2, 19'd2, -1);  // one line short
    frame(VT, -1, 1, 3, 19'd0,  -1);  // frame error at this vsync
    frame(VT, -1, 1, 0, 19'd0,  -1);
    frame(VT, -1, 4, 1, 19'd0,  -1);
    frame(VT, -1, 1, 2, 19'd31,  1);  // reset while hsync/vsync high
    frame(VT, -1, 1, 0, 19'd0,  -1);
    frame(VT, -1, 2, 1, 19'd0,  -1);
    frame(VT, -1, 0, 2, 19'd2,  -1);
    frame(VT, -1, 0, 2, 19'd0,  -1);
    idle(5);
    check("px_q_left",  64'(px_q.size()),  64'(0));
    check("fs_q_left",  64'(fs_q.size()),  64'(0));
    check("err_q_left", 64'(err_q.size()), 64'(0));
    check("lk_q_left",  64'(lk_q.size()),  64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
